// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr, fault} entries with push, pop and a flush that beats push.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 2,
   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
   localparam int CW = $clog2(QDEPTH + 1)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  fetch_entry_t  i_din,
   output fetch_entry_t  o_head,
   output logic [CW-1:0] o_count
);

   fetch_entry_t  r_mem [QDEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;
   logic          w_full;

   assign w_full = (r_count == CW'(QDEPTH));
   assign w_pop  = i_pop && (r_count != '0);
   // A full queue may still accept a push when the head leaves in the same cycle.
   assign w_push = i_push && (!w_full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, fetches into fetch_queue, handles redirect/halt.
// Optional FETCH_IMEM_GATE_EN: imem_en follows push and imem_addr only moves when pc moves.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          QDEPTH     = 2,
   parameter int          IMEM_WORDS = 256
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_fault,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        imem_en
);

   localparam int          CW         = $clog2(QDEPTH + 1);
   localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

   fetch_state_t  r_state;
   logic [31:0]   r_pc;
   logic [CW-1:0] w_count;
   fetch_entry_t  w_head;
   fetch_entry_t  w_din;
   logic          w_out_valid;
   logic          w_pop;
   logic          w_push;
   logic          w_fault;

   assign w_out_valid = (w_count != '0);
   assign w_pop       = w_out_valid && out_ready;
   assign w_push      = (r_state == FETCH) && !redirect_valid &&
                        ((w_count < CW'(QDEPTH)) || w_pop);
   assign w_fault     = ({1'b0, r_pc} >= IMEM_BYTES);
   assign w_din       = '{pc: r_pc, instr: (w_fault ? NOP_INSTR : imem_instr), fault: w_fault};

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_din   (w_din),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // Redirect wins over push and never alters the halt/fetch state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
      end else begin
         if (redirect_valid)
            r_pc <= align_word(redirect_pc);
         else if (w_push)
            r_pc <= r_pc + 32'd4;

         case (r_state)
            BOOT:    r_state <= halt_req ? HALT : FETCH;
            FETCH:   if (halt_req)  r_state <= HALT;
            HALT:    if (!halt_req) r_state <= FETCH;
            default: r_state <= BOOT;
         endcase
      end
   end

   assign out_valid = w_out_valid;
   assign out_instr = w_out_valid ? w_head.instr : NOP_INSTR;
   assign out_pc    = w_out_valid ? w_head.pc    : 32'd0;
   assign out_fault = w_out_valid && w_head.fault;

`ifdef FETCH_IMEM_GATE_EN
   logic [31:0] r_imem_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_imem_addr <= RESET_PC;
      else if (redirect_valid)
         r_imem_addr <= align_word(redirect_pc);
      else if (w_push)
         r_imem_addr <= r_pc + 32'd4;
   end

   assign imem_addr = r_imem_addr;
   assign imem_en   = w_push;
`else
   assign imem_addr = r_pc;
   assign imem_en   = !rst;
`endif

endmodule
